bcd_result_conv: RTL and testbench



---
 rtl/bcd_result_conv.sv | 113 +++++++++++
 tb/tb_bcd_result_conv.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/bcd_result_conv.sv
// bcd_result_conv: signed result to 8 BCD digits via shift-add-3, one bit/cycle.
// Define OVF_CLAMP_EN to show 99999999 on overflow instead of 00000000.
module bcd_result_conv #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] value,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [3:0]       uni,
   output logic [3:0]       ten,
   output logic [3:0]       hun,
   output logic [3:0]       tho,
   output logic [3:0]       tt,
   output logic [3:0]       ht,
   output logic [3:0]       mil,
   output logic [3:0]       tmil,
   output logic             negative,
   output logic             overflow
);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      FINISH
   } state_t;

   localparam logic [5:0] LAST = 6'(WIDTH - 1);

`ifdef OVF_CLAMP_EN
   localparam logic [31:0] OVF_DIGITS = 32'h9999_9999;
`else
   localparam logic [31:0] OVF_DIGITS = 32'h0000_0000;
`endif

   state_t           state;
   logic             sign;
   logic             ovf;
   logic [WIDTH-1:0] mag;
   logic [31:0]      acc;
   logic [5:0]       cnt;

   logic [WIDTH-1:0] mag_in;
   logic [32:0]      mag_ext;
   logic             ovf_in;
   logic [31:0]      adj;

   // Two's-complement negate; the most negative input maps to 2^(WIDTH-1).
   assign mag_in  = value[WIDTH-1]
                  ? (~value) + {{(WIDTH-1){1'b0}}, 1'b1}
                  : value;
   assign mag_ext = {{(33-WIDTH){1'b0}}, mag_in};
   assign ovf_in  = (mag_ext > 33'd99_999_999);

   always_comb begin
      adj = acc;
      for (int i = 0; i < 8; i++) begin
         if (acc[4*i +: 4] >= 4'd5)
            adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         sign     <= 1'b0;
         ovf      <= 1'b0;
         mag      <= '0;
         acc      <= '0;
         cnt      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         negative <= 1'b0;
         overflow <= 1'b0;
         {tmil, mil, ht, tt, tho, hun, ten, uni} <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  sign  <= value[WIDTH-1];
                  mag   <= mag_in;
                  ovf   <= ovf_in;
                  acc   <= '0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               acc <= {adj[30:0], mag[WIDTH-1]};
               mag <= {mag[WIDTH-2:0], 1'b0};
               cnt <= cnt + 6'd1;
               if (cnt == LAST)
                  state <= FINISH;
            end
            FINISH: begin
               {tmil, mil, ht, tt, tho, hun, ten, uni} <=
                  ovf ? OVF_DIGITS : acc;
               negative <= sign;
               overflow <= ovf;
               done     <= 1'b1;
               busy     <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_result_conv.sv
// Bench for bcd_result_conv: directed cases plus random values
// checked against an arithmetic decimal model.
module tb_bcd_result_conv;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] value = '0;
   logic         busy, done, negative, overflow;
   logic [3:0]   uni, ten, hun, tho, tt, ht, mil, tmil;

   int n_tests  = 0;
   int n_fail   = 0;
   int done_cnt = 0;
   int exp_done = 0;

   bcd_result_conv #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .value(value), .start(start),
      .busy(busy), .done(done),
      .uni(uni), .ten(ten), .hun(hun), .tho(tho),
      .tt(tt), .ht(ht), .mil(mil), .tmil(tmil),
      .negative(negative), .overflow(overflow)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (done) done_cnt++;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Returns {negative, overflow, bcd digits tmil..uni}.
   function automatic logic [33:0] model(input logic [31:0] v);
      longint      m;
      logic        neg, ovf;
      logic [31:0] d;
      m   = longint'($signed(v));
      neg = (m < 0);
      if (neg) m = -m;
      ovf = (m > 64'd99_999_999);
      d   = '0;
      if (ovf) begin
`ifdef OVF_CLAMP_EN
         d = 32'h9999_9999;
`endif
      end else begin
         for (int k = 0; k < 8; k++) begin
            d[4*k +: 4] = 4'(m % 10);
            m = m / 10;
         end
      end
      return {neg, ovf, d};
   endfunction

   function automatic logic [31:0] digits();
      return {tmil, mil, ht, tt, tho, hun, ten, uni};
   endfunction

   // Called one step after a rising edge; start is raised at once so a
   // call made in a done cycle exercises back-to-back acceptance.
   task automatic convert(input logic [31:0] v, input int inj);
      logic [33:0] e;
      int          lat;
      e     = model(v);
      value = v;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      value = $urandom;
      exp_done++;
      check("busy_accept", {31'b0, busy}, 1);
      lat = 0;
      for (int n = 1; n <= 40; n++) begin
         if (n == inj) begin
            start = 1'b1;
            value = 32'd7;
         end else if (n == inj + 1) begin
            start = 1'b0;
            value = $urandom;
         end
         @(posedge clk); #1;
         if (done) begin
            lat = n;
            break;
         end
         if (!busy) check("busy_run", {31'b0, busy}, 1);
      end
      start = 1'b0;
      check("latency", lat, 33);
      check("busy_done", {31'b0, busy}, 0);
      check("digits", digits(), e[31:0]);
      check("negative", {31'b0, negative}, {31'b0, e[33]});
      check("overflow", {31'b0, overflow}, {31'b0, e[32]});
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #12;
      check("rst_digits", digits(), 0);
      check("rst_flags", {28'b0, busy, done, negative, overflow}, 0);
      @(posedge clk); #1;
      reset = 1'b1;
      idle(2);

      convert(32'd12_345_678, 0);
      convert(32'hFFFF_FECF, 0);
      convert(32'd0, 0);
      idle(3);
      convert(32'd99_999_999, 0);
      convert(32'd100_000_000, 0);
      convert(32'h8000_0000, 0);
      idle(1);
      convert(32'd42, 10);
      convert(32'd7, 0);

      // Reset in the middle of a conversion.
      value = 32'd12_345_678;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (14) @(posedge clk);
      #4;
      reset = 1'b0;
      #1;
      check("abort_digits", digits(), 0);
      check("abort_flags", {28'b0, busy, done, negative, overflow}, 0);
      idle(3);
      reset = 1'b1;
      idle(40);
      check("abort_nodone", done_cnt, exp_done);
      convert(32'd9, 0);

      for (int i = 0; i < 30; i++) begin
         logic [31:0] v;
         case ($urandom_range(0, 3))
            0: v = $urandom;
            1: v = $urandom_range(0, 99_999_999);
            2: v = -$urandom_range(0, 99_999_999);
            default: begin
               v = 32'd99_999_998 + $urandom_range(0, 3);
               if ($urandom_range(0, 1) == 1) v = -v;
            end
         endcase
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
         convert(v, 0);
      end

      @(negedge clk); #1;
      check("done_count", done_cnt, exp_done);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
